regfile_wb_scheduler: RTL and testbench

- Write-back scheduler in front of a single-write-port 15-entry register file (RNONE = 4'hF means "no register").
- Accepts one instruction's write-back pair (dstE/valE, dstM/valM) per handshake and serialises it into at most two register-file writes: E first, then M.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on srcA/srcB.

---
 rtl/regfile_wb_scheduler.sv | 173 +++++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Write-back scheduler in front of a single-write-port register
//            file. Each accepted instruction write-back pair (E, M) becomes at
//            most two register-file writes, issued E first and then M. A
//            pending-write scoreboard lets decode detect read-after-write
//            hazards on srcA/srcB.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            wb_valid/wb_ready          - write-back pair handshake
//            dstE/valE, dstM/valM       - write-back pair (RNONE = no write)
//            rf_we/rf_waddr/rf_wdata    - registered register-file write port
//            srcA/srcB                  - decode read IDs
//            hazA/hazB                  - pending-write hazard flags
//            fwdA_*/fwdB_*              - bypass hit/data (optional feature)
// Options  : define REGWB_BYPASS_EN to forward buffered data to decode and
//            suppress the matching hazard; otherwise fwd* outputs are 0.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int               DATA_W = 32,
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_W-1:0]  dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [REG_W-1:0]  dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [REG_W-1:0]  srcA,
    input  logic [REG_W-1:0]  srcB,
    output logic              hazA,
    output logic              hazB,
    output logic              fwdA_hit,
    output logic [DATA_W-1:0] fwdA_data,
    output logic              fwdB_hit,
    output logic [DATA_W-1:0] fwdB_data
);

    // One scoreboard bit per encodable ID; the RNONE bit is never set
    // because a write to RNONE is never needed.
    localparam int c_NUM_IDS = 1 << REG_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR_E = 2'd1,
        S_WR_M = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_needM;
    logic [REG_W-1:0]      r_dstM;
    logic [DATA_W-1:0]     r_valM;
`ifdef REGWB_BYPASS_EN
    logic [DATA_W-1:0]     r_valE;
`endif
    logic [c_NUM_IDS-1:0]  r_pending;
    logic [c_NUM_IDS-1:0]  w_pendingNext;

    logic w_needE;
    logic w_needM;
    logic w_accept;
    logic w_pendA;
    logic w_pendB;

    // M wins when both halves target the same register, so E is dropped.
    assign w_needM = (dstM != RNONE);
    assign w_needE = (dstE != RNONE) && !(w_needM && (dstE == dstM));

    // Ready in IDLE or during the last write of a pair, which lets a new
    // pair be accepted on the same edge that retires the previous one.
    assign wb_ready = (r_state == S_IDLE) || (r_state == S_WR_M) ||
                      ((r_state == S_WR_E) && !r_needM);
    assign w_accept = wb_valid && wb_ready;

    // Clear the bit being written this cycle first, then apply the new
    // pair's sets so a set on the same register takes priority.
    always_comb begin
        w_pendingNext = r_pending;
        if (rf_we) begin
            w_pendingNext[rf_waddr] = 1'b0;
        end
        if (w_accept && w_needE) begin
            w_pendingNext[dstE] = 1'b1;
        end
        if (w_accept && w_needM) begin
            w_pendingNext[dstM] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_needM   <= 1'b0;
            r_dstM    <= RNONE;
            r_valM    <= '0;
`ifdef REGWB_BYPASS_EN
            r_valE    <= '0;
`endif
            r_pending <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= RNONE;
            rf_wdata  <= '0;
        end else begin
            r_pending <= w_pendingNext;
            if (w_accept) begin
                r_needM <= w_needM;
                r_dstM  <= dstM;
                r_valM  <= valM;
`ifdef REGWB_BYPASS_EN
                r_valE  <= valE;
`endif
                // The first write goes straight from the inputs into the
                // output flops so it appears the cycle after acceptance.
                if (w_needE) begin
                    r_state  <= S_WR_E;
                    rf_we    <= 1'b1;
                    rf_waddr <= dstE;
                    rf_wdata <= valE;
                end else if (w_needM) begin
                    r_state  <= S_WR_M;
                    rf_we    <= 1'b1;
                    rf_waddr <= dstM;
                    rf_wdata <= valM;
                end else begin
                    r_state  <= S_IDLE;
                    rf_we    <= 1'b0;
                    rf_waddr <= RNONE;
                    rf_wdata <= '0;
                end
            end else if ((r_state == S_WR_E) && r_needM) begin
                r_state  <= S_WR_M;
                rf_we    <= 1'b1;
                rf_waddr <= r_dstM;
                rf_wdata <= r_valM;
            end else begin
                r_state  <= S_IDLE;
                rf_we    <= 1'b0;
                rf_waddr <= RNONE;
                rf_wdata <= '0;
            end
        end
    end

    assign w_pendA = (srcA != RNONE) && r_pending[srcA];
    assign w_pendB = (srcB != RNONE) && r_pending[srcB];

`ifdef REGWB_BYPASS_EN
    // Pending bits only ever describe the currently buffered pair, so the
    // buffer always holds the value about to be written to a pending ID.
    assign fwdA_hit  = w_pendA;
    assign fwdA_data = !w_pendA ? '0 : ((srcA == r_dstM) ? r_valM : r_valE);
    assign fwdB_hit  = w_pendB;
    assign fwdB_data = !w_pendB ? '0 : ((srcB == r_dstM) ? r_valM : r_valE);
    assign hazA      = 1'b0;
    assign hazB      = 1'b0;
`else
    assign fwdA_hit  = 1'b0;
    assign fwdA_data = '0;
    assign fwdB_hit  = 1'b0;
    assign fwdB_data = '0;
    assign hazA      = w_pendA;
    assign hazB      = w_pendB;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Self-checking bench for regfile_wb_scheduler. A queue model of
//            outstanding register writes predicts every output each cycle;
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [3:0]  dstE = 4'hF;
    logic [31:0] valE = '0;
    logic [3:0]  dstM = 4'hF;
    logic [31:0] valM = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  srcA = 4'hF;
    logic [3:0]  srcB = 4'hF;
    logic        hazA, hazB, fwdA_hit, fwdB_hit;
    logic [31:0] fwdA_data, fwdB_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.DATA_W(32), .REG_W(4), .RNONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .srcA(srcA), .srcB(srcB), .hazA(hazA), .hazB(hazB),
        .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
        .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: ordered list of writes not yet retired --------
    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q[$];
    wr_t mTmp;
    bit  mRdy;
    bit  mNeedM;

    // Head of the list is on the bus this cycle; a pair is accepted when at
    // most that one write remains.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            mRdy   = (q.size() <= 1);
            mNeedM = (dstM != 4'hF);
            if (q.size() > 0) void'(q.pop_front());
            if (wb_valid && mRdy) begin
                if (dstE != 4'hF && !(mNeedM && dstE == dstM)) begin
                    mTmp.a = dstE; mTmp.d = valE; q.push_back(mTmp);
                end
                if (mNeedM) begin
                    mTmp.a = dstM; mTmp.d = valM; q.push_back(mTmp);
                end
            end
        end
    end

    logic        eWe, eRdy, pA, pB;
    logic [3:0]  eAddr;
    logic [31:0] eData, dA, dB;

    always @(negedge clk) begin
        eWe   = (q.size() > 0);
        eAddr = eWe ? q[0].a : 4'hF;
        eData = eWe ? q[0].d : 32'h0;
        eRdy  = (q.size() <= 1);
        pA = 1'b0; dA = '0; pB = 1'b0; dB = '0;
        foreach (q[i]) begin
            if (q[i].a == srcA) begin pA = 1'b1; dA = q[i].d; end
            if (q[i].a == srcB) begin pB = 1'b1; dB = q[i].d; end
        end
        chk("m_rf_we", {31'b0, rf_we}, {31'b0, eWe});
        chk("m_rf_waddr", {28'b0, rf_waddr}, {28'b0, eAddr});
        chk("m_rf_wdata", rf_wdata, eData);
        chk("m_wb_ready", {31'b0, wb_ready}, {31'b0, eRdy});
`ifdef REGWB_BYPASS_EN
        chk("m_hazA", {31'b0, hazA}, 32'h0);
        chk("m_hazB", {31'b0, hazB}, 32'h0);
        chk("m_fwdA_hit", {31'b0, fwdA_hit}, {31'b0, pA});
        chk("m_fwdA_data", fwdA_data, dA);
        chk("m_fwdB_hit", {31'b0, fwdB_hit}, {31'b0, pB});
        chk("m_fwdB_data", fwdB_data, dB);
`else
        chk("m_hazA", {31'b0, hazA}, {31'b0, pA});
        chk("m_hazB", {31'b0, hazB}, {31'b0, pB});
        chk("m_fwdA_hit", {31'b0, fwdA_hit}, 32'h0);
        chk("m_fwdA_data", fwdA_data, 32'h0);
        chk("m_fwdB_hit", {31'b0, fwdB_hit}, 32'h0);
        chk("m_fwdB_data", fwdB_data, 32'h0);
`endif
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, hold it while not ready, return just after the
    // accepting edge with wb_valid still high.
    task automatic send(input logic [3:0] dE, input logic [31:0] vE,
                        input logic [3:0] dM, input logic [31:0] vM);
        int n;
        wb_valid = 1'b1;
        dstE = dE; valE = vE; dstM = dM; valM = vM;
        n = 0;
        while (!wb_ready && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: wb_ready still %0b after %0d cycles", wb_ready, n);
        end
        cyc();
    endtask

    task automatic stop();
        wb_valid = 1'b0;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    endtask

    // ---------------- directed scenarios ----------------------------------
    initial begin
        repeat (2) cyc();
        chk("rst_we", {31'b0, rf_we}, 32'h0);
        chk("rst_waddr", {28'b0, rf_waddr}, 32'hF);
        chk("rst_ready", {31'b0, wb_ready}, 32'h1);
        rst_n = 1'b1;
        cyc();

        // Single E write
        send(4'd3, 32'h11, 4'hF, 32'h0);
        stop();
        chk("se_we", {31'b0, rf_we}, 32'h1);
        chk("se_addr", {28'b0, rf_waddr}, 32'h3);
        chk("se_data", rf_wdata, 32'h11);
        chk("se_ready", {31'b0, wb_ready}, 32'h1);
        cyc();
        chk("se_done", {31'b0, rf_we}, 32'h0);

        // popq-style pair
        srcA = 4'd0; srcB = 4'd4;
        send(4'd4, 32'h100, 4'd0, 32'hAA);
        stop();
        chk("pq_addr1", {28'b0, rf_waddr}, 32'h4);
        chk("pq_data1", rf_wdata, 32'h100);
        chk("pq_ready1", {31'b0, wb_ready}, 32'h0);
`ifdef REGWB_BYPASS_EN
        chk("pq_fwdA1", fwdA_data, 32'hAA);
`else
        chk("pq_hazA1", {31'b0, hazA}, 32'h1);
`endif
        cyc();
        chk("pq_addr2", {28'b0, rf_waddr}, 32'h0);
        chk("pq_data2", rf_wdata, 32'hAA);
        chk("pq_ready2", {31'b0, wb_ready}, 32'h1);
`ifndef REGWB_BYPASS_EN
        chk("pq_hazA2", {31'b0, hazA}, 32'h1);
        chk("pq_hazB2", {31'b0, hazB}, 32'h0);
`endif
        cyc();
        chk("pq_done", {31'b0, rf_we}, 32'h0);
        chk("pq_hazA3", {31'b0, hazA}, 32'h0);
        srcA = 4'hF; srcB = 4'hF;

        // Equal IDs: only the M write
        send(4'd4, 32'h100, 4'd4, 32'h55);
        stop();
        chk("eq_addr", {28'b0, rf_waddr}, 32'h4);
        chk("eq_data", rf_wdata, 32'h55);
        chk("eq_ready", {31'b0, wb_ready}, 32'h1);
        cyc();
        chk("eq_done", {31'b0, rf_we}, 32'h0);

        // Back-to-back single-write pairs, then a no-write pair
        send(4'd1, 32'h21, 4'hF, 32'h0);
        chk("bb_addr1", {28'b0, rf_waddr}, 32'h1);
        send(4'd2, 32'h22, 4'hF, 32'h0);
        chk("bb_addr2", {28'b0, rf_waddr}, 32'h2);
        send(4'hF, 32'h0, 4'd3, 32'h23);
        chk("bb_addr3", {28'b0, rf_waddr}, 32'h3);
        chk("bb_data3", rf_wdata, 32'h23);
        send(4'hF, 32'h0, 4'hF, 32'h0);
        chk("bb_none", {31'b0, rf_we}, 32'h0);

        // Two-write pair followed by a held pair
        send(4'd8, 32'h88, 4'd9, 32'h99);
        send(4'd10, 32'hAB, 4'hF, 32'h0);
        stop();
        chk("hold_addr", {28'b0, rf_waddr}, 32'hA);
        chk("hold_data", rf_wdata, 32'hAB);
        cyc();

        // Bypass / hazard on both read ports
        srcA = 4'd5; srcB = 4'd2;
        send(4'd2, 32'h7, 4'd5, 32'h9);
        stop();
`ifdef REGWB_BYPASS_EN
        chk("bp_fwdA_hit", {31'b0, fwdA_hit}, 32'h1);
        chk("bp_fwdA_data", fwdA_data, 32'h9);
        chk("bp_fwdB_hit", {31'b0, fwdB_hit}, 32'h1);
        chk("bp_fwdB_data", fwdB_data, 32'h7);
        chk("bp_hazA", {31'b0, hazA}, 32'h0);
        chk("bp_hazB", {31'b0, hazB}, 32'h0);
`else
        chk("bp_hazA", {31'b0, hazA}, 32'h1);
        chk("bp_hazB", {31'b0, hazB}, 32'h1);
        chk("bp_fwdA_hit", {31'b0, fwdA_hit}, 32'h0);
        chk("bp_fwdB_data", fwdB_data, 32'h0);
`endif
        repeat (2) cyc();
        srcA = 4'hF; srcB = 4'hF;

        // Asynchronous reset during WR_E discards the pending M write
        srcA = 4'd7;
        send(4'd6, 32'h66, 4'd7, 32'h77);
        stop();
        chk("rw_addr", {28'b0, rf_waddr}, 32'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_we", {31'b0, rf_we}, 32'h0);
        chk("rw_waddr", {28'b0, rf_waddr}, 32'hF);
        chk("rw_ready", {31'b0, wb_ready}, 32'h1);
        chk("rw_hazA", {31'b0, hazA}, 32'h0);
        chk("rw_fwdA", {31'b0, fwdA_hit}, 32'h0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rw_post_we", {31'b0, rf_we}, 32'h0);
            chk("rw_post_hazA", {31'b0, hazA}, 32'h0);
        end
        srcA = 4'hF;

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
